// File: rtl/pll_lock_ctrl_if.sv
// rtl/pll_lock_ctrl_if.sv - signal bundle between the PLL lock supervisor and the clock generator / system reset consumers
interface pll_lock_ctrl_if;
    logic       locked;
    logic       pll_reset;
    logic       sys_rst_n;
    logic       pll_ready;
    logic       lock_lost;
    logic [7:0] retry_cnt;
    logic       fail;

    modport master (
        input  locked,
        output pll_reset, sys_rst_n, pll_ready, lock_lost, retry_cnt, fail
    );

    modport slave (
        output locked,
        input  pll_reset, sys_rst_n, pll_ready, lock_lost, retry_cnt, fail
    );
endinterface

// File: rtl/pll_lock_ctrl.sv
// rtl/pll_lock_ctrl.sv - PLL reset/lock supervisor; retry limit and FAIL state enabled by PLL_LOCK_CTRL_RETRY_LIMIT_EN
module pll_lock_ctrl #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 100000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRY     = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    pll_lock_ctrl_if.master bus
);
`ifdef PLL_LOCK_CTRL_RETRY_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    localparam int MAX_AB = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_ALL = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
    localparam int CW = ($clog2(MAX_ALL) < 1) ? 1 : $clog2(MAX_ALL);
    localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STB_LAST = CW'(STABLE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    sync_q;
    logic          locked_s;
    logic [7:0]    retry_q, retry_d;
    logic          pll_reset_q, sys_rst_n_q, pll_ready_q, lock_lost_q, fail_q;
    logic          lost_d, bump;

    assign locked_s = sync_q[1];

    always_comb begin
        state_d = state_q;
        bump    = 1'b0;
        lost_d  = 1'b0;
        case (state_q)
            ST_PLL_RST:   if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
            ST_WAIT_LOCK: begin
                if (locked_s)               state_d = ST_STABLE;
                else if (cnt_q == TO_LAST)  bump = 1'b1;
            end
            ST_STABLE: begin
                if (!locked_s)              bump = 1'b1;
                else if (cnt_q == STB_LAST) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!locked_s) begin
                    bump   = 1'b1;
                    lost_d = 1'b1;
                end
            end
            ST_FAIL:      state_d = ST_FAIL;
            default:      state_d = ST_PLL_RST;
        endcase

        retry_d = (bump && retry_q != 8'hFF) ? retry_q + 8'd1 : retry_q;
        // Every failed attempt re-resets the PLL unless the armed limit has been reached.
        if (bump) state_d = (LIMIT_EN && int'(retry_d) >= MAX_RETRY) ? ST_FAIL : ST_PLL_RST;
        cnt_d = (state_d != state_q) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= 2'b00;
            state_q     <= ST_PLL_RST;
            cnt_q       <= '0;
            retry_q     <= 8'd0;
            pll_reset_q <= 1'b1;
            sys_rst_n_q <= 1'b0;
            pll_ready_q <= 1'b0;
            lock_lost_q <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], bus.locked};
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            pll_reset_q <= (state_d == ST_PLL_RST) || (state_d == ST_FAIL);
            sys_rst_n_q <= (state_d == ST_RUN);
            pll_ready_q <= (state_d == ST_RUN);
            lock_lost_q <= lost_d;
            fail_q      <= LIMIT_EN && (state_d == ST_FAIL);
        end
    end

    assign bus.pll_reset = pll_reset_q;
    assign bus.sys_rst_n = sys_rst_n_q;
    assign bus.pll_ready = pll_ready_q;
    assign bus.lock_lost = lock_lost_q;
    assign bus.retry_cnt = retry_q;
    assign bus.fail      = fail_q;
endmodule

// File: tb/tb_pll_lock_ctrl.sv
// tb/tb_pll_lock_ctrl.sv - directed/randomized bench for pll_lock_ctrl against timing rules derived from the supervisor's behaviour
module tb_pll_lock_ctrl;
    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 16;
    localparam int STABLE_CYCLES = 8;
    localparam int MAX_RETRY     = 3;
    localparam int SYNC_LAT      = 2;
    localparam int LOCK_TO_RUN   = SYNC_LAT + 1 + STABLE_CYCLES;
    localparam int MAX_LATE_LOCK = LOCK_TIMEOUT - SYNC_LAT - 1;

    localparam int SIG_PLL_RST = 0;
    localparam int SIG_SYS_RST = 1;
    localparam int SIG_LOST    = 2;
    localparam int SIG_FAIL    = 3;
    localparam int SIG_READY   = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    pll_lock_ctrl_if bus ();

    pll_lock_ctrl #(
        .RST_CYCLES    (RST_CYCLES),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .STABLE_CYCLES (STABLE_CYCLES),
        .MAX_RETRY     (MAX_RETRY)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic get_sig(input int which);
        case (which)
            SIG_PLL_RST: return bus.pll_reset;
            SIG_SYS_RST: return bus.sys_rst_n;
            SIG_LOST:    return bus.lock_lost;
            SIG_FAIL:    return bus.fail;
            default:     return bus.pll_ready;
        endcase
    endfunction

    // Cycles until the signal reaches val; an expired bound shows up as a failed "_seen" check.
    task automatic wait_sig(input string tag, input int which, input logic val, input int limit, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (get_sig(which) !== val && n < limit);
        check({tag, "_seen"}, get_sig(which), val);
    endtask

    task automatic hold_check(input string tag, input int which, input logic val, input int cycles);
        int bad = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (get_sig(which) !== val) bad++;
        end
        check(tag, bad, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pll_reset"}, bus.pll_reset, 1);
        check({tag, "_sys_rst_n"}, bus.sys_rst_n, 0);
        check({tag, "_pll_ready"}, bus.pll_ready, 0);
        check({tag, "_lock_lost"}, bus.lock_lost, 0);
        check({tag, "_retry_cnt"}, bus.retry_cnt, 0);
        check({tag, "_fail"},      bus.fail, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, d, bad, exp_retry;
        bus.locked = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();
        check_reset_outputs("por");

        // Clean start, lock 5 cycles after pll_reset falls
        rst_n = 1'b1;
        wait_sig("clean_rst", SIG_PLL_RST, 1'b0, 50, n);
        check("clean_pll_reset_len", n, RST_CYCLES);
        repeat (5) tick();
        bus.locked = 1'b1;
        wait_sig("clean_run", SIG_SYS_RST, 1'b1, 100, n);
        check("clean_lock_to_sysrst", n, LOCK_TO_RUN);
        check("clean_ready", bus.pll_ready, 1);
        check("clean_pll_reset_low", bus.pll_reset, 0);
        check("clean_retry", bus.retry_cnt, 0);

        // Lock loss in RUN after a random dwell
        hold_check("run_dwell", SIG_READY, 1'b1, $urandom_range(3, 20));
        bus.locked = 1'b0;
        wait_sig("loss", SIG_LOST, 1'b1, 20, n);
        check("loss_latency", n, SYNC_LAT + 1);
        check("loss_sys_rst_n", bus.sys_rst_n, 0);
        check("loss_ready", bus.pll_ready, 0);
        check("loss_pll_reset", bus.pll_reset, 1);
        check("loss_retry", bus.retry_cnt, 1);
        bus.locked = 1'b1;
        tick();
        check("loss_pulse_width", bus.lock_lost, 0);
        wait_sig("relock_rst", SIG_PLL_RST, 1'b0, 20, n);
        check("relock_rst_remaining", n, RST_CYCLES - 1);
        wait_sig("relock_run", SIG_SYS_RST, 1'b1, 50, n);
        check("relock_to_run", n, 1 + STABLE_CYCLES);
        check("relock_retry", bus.retry_cnt, 1);

        // Asynchronous reset in the middle of a cycle while running
        repeat ($urandom_range(1, 6)) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async");
        bus.locked = 1'b0;
        repeat (2) tick();

        // Glitch on locked at STABLE cycle 5: the drop lands on the terminal-count edge
        rst_n = 1'b1;
        wait_sig("glitch_rst", SIG_PLL_RST, 1'b0, 50, n);
        repeat ($urandom_range(0, 5)) tick();
        bus.locked = 1'b1;
        hold_check("glitch_pre_stable", SIG_SYS_RST, 1'b0, SYNC_LAT + 1 + 5);
        bus.locked = 1'b0;
        tick();
        bad = int'(bus.sys_rst_n);
        bus.locked = 1'b1;
        wait_sig("glitch", SIG_PLL_RST, 1'b1, 20, n);
        check("glitch_latency", n, SYNC_LAT);
        check("glitch_no_release", bad + int'(bus.sys_rst_n), 0);
        check("glitch_retry", bus.retry_cnt, 1);
        wait_sig("glitch_rerst", SIG_PLL_RST, 1'b0, 20, n);
        check("glitch_rerst_len", n, RST_CYCLES);
        wait_sig("glitch_recover", SIG_SYS_RST, 1'b1, 50, n);
        check("glitch_recover_time", n, 1 + STABLE_CYCLES);

        // Random lock arrival within the window; first round locks on the timeout edge itself
        for (int r = 0; r < 4; r++) begin
            rst_n = 1'b0;
            bus.locked = 1'b0;
            repeat (2) tick();
            rst_n = 1'b1;
            wait_sig("rand_rst", SIG_PLL_RST, 1'b0, 50, n);
            d = (r == 0) ? MAX_LATE_LOCK : $urandom_range(0, MAX_LATE_LOCK);
            repeat (d) tick();
            bus.locked = 1'b1;
            wait_sig("rand_run", SIG_SYS_RST, 1'b1, 100, n);
            check($sformatf("rand_lock_to_run_d%0d", d), n, LOCK_TO_RUN);
            check("rand_retry", bus.retry_cnt, 0);
        end

        // Repeated timeouts with locked held low
        rst_n = 1'b0;
        bus.locked = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        wait_sig("to_first_rst", SIG_PLL_RST, 1'b0, 50, n);
        check("to_first_rst_len", n, RST_CYCLES);
`ifdef PLL_LOCK_CTRL_RETRY_LIMIT_EN
        for (int i = 1; i <= MAX_RETRY; i++) begin
            wait_sig("to_rise", SIG_PLL_RST, 1'b1, 40, n);
            check($sformatf("to_period_%0d", i), n, LOCK_TIMEOUT);
            check($sformatf("to_retry_%0d", i), bus.retry_cnt, i);
            if (i < MAX_RETRY) begin
                check("to_fail_low", bus.fail, 0);
                wait_sig("to_fall", SIG_PLL_RST, 1'b0, 20, n);
                check("to_rst_len", n, RST_CYCLES);
            end else begin
                check("fail_flag", bus.fail, 1);
                hold_check("fail_pll_reset_stuck", SIG_PLL_RST, 1'b1, 3 * LOCK_TIMEOUT);
                check("fail_flag_held", bus.fail, 1);
                check("fail_retry_held", bus.retry_cnt, MAX_RETRY);
                check("fail_sys_rst_n", bus.sys_rst_n, 0);
            end
        end
`else
        bad = 0;
        for (int i = 1; i <= 300; i++) begin
            wait_sig("to_rise", SIG_PLL_RST, 1'b1, 40, n);
            if (n != LOCK_TIMEOUT) bad++;
            exp_retry = (i > 255) ? 255 : i;
            if (i <= 5 || i == 254 || i == 255 || i == 256 || i == 300)
                check($sformatf("to_retry_%0d", i), bus.retry_cnt, exp_retry);
            wait_sig("to_fall", SIG_PLL_RST, 1'b0, 20, n);
            if (n != RST_CYCLES) bad++;
        end
        check("to_period_errors", bad, 0);
        check("to_fail_tied_low", bus.fail, 0);
        check("to_sys_rst_n", bus.sys_rst_n, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
